// File: rtl/ws2812_rx.sv
`timescale 1ns/1ps
// WS2812 (NeoPixel) serial receiver: decodes GRB pixels from a pulse-width
// coded stream, frames on the low reset gap and forwards the chain on dout.
module ws2812_rx #(
    parameter int BIT_THRESH   = 30,
    parameter int MIN_HIGH     = 8,
    parameter int MAX_HIGH     = 60,
    parameter int RESET_CYCLES = 2500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        din,
    output logic [23:0] pix_data,
    output logic        pix_valid,
    output logic [6:0]  pix_index,
    output logic [6:0]  pix_count,
    output logic        frame_done,
    output logic        err,
    output logic        ovf,
    output logic        dout,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {ST_ARM, ST_IDLE, ST_HIGH, ST_LOW} state_t;

    localparam logic [11:0] LC_THR = 12'(BIT_THRESH);
    localparam logic [11:0] LC_MIN = 12'(MIN_HIGH);
    localparam logic [11:0] LC_MAX = 12'(MAX_HIGH);
    localparam logic [11:0] LC_GAP = 12'(RESET_CYCLES - 1);

    state_t      r_state, w_state_nxt;
    logic        r_sync1, r_din_s, r_din_d;
    logic [11:0] r_hi_cnt, r_lo_cnt;
    logic [4:0]  r_bit_cnt;
    logic [22:0] r_shift;
    logic [6:0]  r_pix_cnt;
    logic        r_fwd;

    // Decode-stage events, re-registered once more to form the output strobes
    logic        r_ev_pix, r_ev_err, r_ev_frame, r_ev_gap, r_ev_ovf;
    logic [23:0] r_ev_data;
    logic [6:0]  r_ev_idx, r_ev_cnt;

    logic        w_rise, w_fall, w_gap, w_decode, w_bad, w_bit;
    logic        w_accept, w_word_done, w_active;
    logic [11:0] w_hi_inc, w_lo_inc;

    assign w_rise      = r_din_s & ~r_din_d;
    assign w_fall      = ~r_din_s & r_din_d;
    assign w_hi_inc    = (r_hi_cnt == 12'hFFF) ? r_hi_cnt : r_hi_cnt + 12'd1;
    assign w_lo_inc    = (r_lo_cnt == 12'hFFF) ? r_lo_cnt : r_lo_cnt + 12'd1;
    assign w_gap       = (r_state == ST_LOW) && !w_rise && (r_lo_cnt == LC_GAP);
    assign w_decode    = (r_state == ST_HIGH) && w_fall;
    assign w_bad       = (r_hi_cnt < LC_MIN) || (r_hi_cnt > LC_MAX);
    assign w_bit       = r_hi_cnt > LC_THR;
    assign w_accept    = w_decode && !w_bad;
    assign w_word_done = w_accept && (r_bit_cnt == 5'd23);
    assign w_active    = (r_bit_cnt != 5'd0) || (r_pix_cnt != 7'd0);

    assign dout      = r_fwd & r_din_d;
    assign dbg_state = r_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_din_s <= 1'b0;
            r_din_d <= 1'b0;
            r_state <= ST_ARM;
        end else begin
            r_sync1 <= din;
            r_din_s <= r_sync1;
            r_din_d <= r_din_s;
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_ARM:  if (!r_din_s && r_lo_cnt == LC_GAP) w_state_nxt = ST_IDLE;
            ST_IDLE: if (w_rise) w_state_nxt = ST_HIGH;
            ST_HIGH: if (w_fall) w_state_nxt = ST_LOW;
            ST_LOW: begin
                if (w_rise)     w_state_nxt = ST_HIGH;
                else if (w_gap) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_ARM;
        endcase
    end

    // Pulse timing, bit assembly and frame bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hi_cnt   <= '0;
            r_lo_cnt   <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_pix_cnt  <= '0;
            r_ev_pix   <= 1'b0;
            r_ev_err   <= 1'b0;
            r_ev_frame <= 1'b0;
            r_ev_gap   <= 1'b0;
            r_ev_ovf   <= 1'b0;
            r_ev_data  <= '0;
            r_ev_idx   <= '0;
            r_ev_cnt   <= '0;
        end else begin
            case (r_state)
                ST_ARM:  r_lo_cnt <= r_din_s ? 12'd0 : w_lo_inc;
                ST_IDLE: if (w_rise) r_hi_cnt <= 12'd1;
                ST_HIGH: begin
                    if (w_fall) r_lo_cnt <= 12'd1;
                    else        r_hi_cnt <= w_hi_inc;
                end
                ST_LOW: begin
                    if (w_rise) r_hi_cnt <= 12'd1;
                    else        r_lo_cnt <= w_lo_inc;
                end
                default: r_lo_cnt <= '0;
            endcase

            r_ev_pix   <= w_word_done;
            r_ev_err   <= (w_decode && w_bad) || (w_gap && r_bit_cnt != 5'd0);
            r_ev_frame <= w_gap && w_active;
            r_ev_gap   <= w_gap;
            r_ev_ovf   <= w_word_done && (r_pix_cnt == 7'd127);

            if (w_accept) begin
                r_shift   <= {r_shift[21:0], w_bit};
                r_bit_cnt <= w_word_done ? 5'd0 : r_bit_cnt + 5'd1;
            end
            if (w_word_done) begin
                r_ev_data <= {r_shift, w_bit};
                r_ev_idx  <= r_pix_cnt;
                if (r_pix_cnt != 7'd127) r_pix_cnt <= r_pix_cnt + 7'd1;
            end
            if (w_gap) begin
                r_ev_cnt  <= r_pix_cnt;
                r_pix_cnt <= '0;
                r_bit_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_data   <= '0;
            pix_valid  <= 1'b0;
            pix_index  <= '0;
            pix_count  <= '0;
            frame_done <= 1'b0;
            err        <= 1'b0;
            ovf        <= 1'b0;
            r_fwd      <= 1'b0;
        end else begin
            pix_valid  <= r_ev_pix;
            frame_done <= r_ev_frame;
            err        <= r_ev_err;
            if (r_ev_pix) begin
                pix_data  <= r_ev_data;
                pix_index <= r_ev_idx;
            end
            if (r_ev_frame) pix_count <= r_ev_cnt;
            if (r_ev_gap)      ovf <= 1'b0;
            else if (r_ev_ovf) ovf <= 1'b1;
            // Forward flag only moves while the line is low so dout never
            // emits a truncated pulse.
            if (!r_din_s) begin
                if (r_ev_gap || r_state == ST_ARM)         r_fwd <= 1'b0;
                else if (r_ev_pix && r_ev_idx == 7'd0)     r_fwd <= 1'b1;
            end
        end
    end

endmodule
